// File: rtl/uart_rx_monitor.sv
// UART receiver/monitor with configurable frame format, sticky error flags and a FWFT capture FIFO.
// Optional expected-data compare on pop is enabled by defining UART_RX_MONITOR_EXPECT_EN.
module uart_rx_monitor #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
`ifdef UART_RX_MONITOR_EXPECT_EN
  input  logic [DATA_BITS-1:0]          exp_data,
  output logic                          mismatch,
  output logic [15:0]                   mismatch_cnt,
`endif
  input  logic                          err_clr
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUDRATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic                 sync1, rxs, rxs_prev;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          level;
  logic                 push, pop, full, push_ok;

  assign busy     = (state != IDLE);
  assign push     = (state == STOP) && (cnt == CNT_LAST) && (bit_idx == 4'(STOP_BITS - 1));
  assign full     = (level == (AW+1)'(FIFO_DEPTH));
  assign rx_valid = (level != '0);
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push && (!full || pop);
  assign rx_level = level;
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      rxs_prev   <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sync1    <= uart_rx;
      rxs      <= sync1;
      rxs_prev <= rxs;
      if (err_clr) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      // Start-bit check at mid-bit; every later sample lands one full bit period after it.
      case (state)
        IDLE: begin
          if (rxs_prev && !rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAR: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= STOP;
            if ((^shreg ^ rxs) != PAR_ODD) parity_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!rxs) frame_err <= 1'b1;
            if (bit_idx == 4'(STOP_BITS - 1)) begin
              bit_idx <= '0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push_ok) - (AW+1)'(pop);
      if (err_clr)                overrun <= 1'b0;
      if (push && full && !pop)   overrun <= 1'b1;
    end
  end

`ifdef UART_RX_MONITOR_EXPECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      if (err_clr) mismatch <= 1'b0;
      if (pop && (rx_data != exp_data)) begin
        mismatch <= 1'b1;
        if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: an 8N1 instance and an 8E1 instance at 10 clocks per bit.
module tb_uart_rx_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       line0, line1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1, rx_ready0, rx_ready1;
  logic [4:0] rx_level0, rx_level1;
  logic       busy0, busy1, ferr0, ferr1, perr0, perr1, ovr0, ovr1;
  logic       err_clr0, err_clr1;
`ifdef UART_RX_MONITOR_EXPECT_EN
  logic [7:0]  exp0, exp1;
  logic        mis0, mis1;
  logic [15:0] mcnt0, mcnt1;
`endif

  int checks = 0;
  int failures = 0;
  int vcnt0 = 0;
  logic [7:0] cap0[$];
  logic [7:0] cap1[$];

  always #5 clk = ~clk;

  uart_rx_monitor #(.CLK_HZ(50000000), .BAUDRATE(5000000), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut (
    .clk(clk), .reset(reset), .uart_rx(line0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready0), .rx_level(rx_level0), .busy(busy0), .frame_err(ferr0),
    .parity_err(perr0), .overrun(ovr0),
`ifdef UART_RX_MONITOR_EXPECT_EN
    .exp_data(exp0), .mismatch(mis0), .mismatch_cnt(mcnt0),
`endif
    .err_clr(err_clr0));

  uart_rx_monitor #(.CLK_HZ(50000000), .BAUDRATE(5000000), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut_par (
    .clk(clk), .reset(reset), .uart_rx(line1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_ready(rx_ready1), .rx_level(rx_level1), .busy(busy1), .frame_err(ferr1),
    .parity_err(perr1), .overrun(ovr1),
`ifdef UART_RX_MONITOR_EXPECT_EN
    .exp_data(exp1), .mismatch(mis1), .mismatch_cnt(mcnt1),
`endif
    .err_clr(err_clr1));

  // Record every accepted word, as the consumer would see it.
  always @(negedge clk) begin
    if (rx_valid0 && rx_ready0) cap0.push_back(rx_data0);
    if (rx_valid1 && rx_ready1) cap1.push_back(rx_data1);
    if (rx_valid0) vcnt0++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_bit(input int ln, input logic v);
    if (ln == 0) line0 = v; else line1 = v;
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input int ln, input logic [7:0] d, input bit par_en, input bit par,
                      input bit stopv);
    drive_bit(ln, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(ln, d[i]);
    if (par_en) drive_bit(ln, par);
    drive_bit(ln, stopv);
    drive_bit(ln, 1'b1);
    drive_bit(ln, 1'b1);
  endtask

  initial begin
    reset = 1'b1; line0 = 1'b1; line1 = 1'b1;
    rx_ready0 = 1'b1; rx_ready1 = 1'b1; err_clr0 = 1'b0; err_clr1 = 1'b0;
`ifdef UART_RX_MONITOR_EXPECT_EN
    exp0 = 8'h00; exp1 = 8'h00;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(rx_valid0), 32'd0);
    check("rst_level", 32'(rx_level0), 32'd0);
    check("rst_data",  32'(rx_data0),  32'd0);
    check("rst_busy",  32'(busy0),     32'd0);
    check("rst_flags", {29'd0, ferr0, perr0, ovr0}, 32'd0);

    // 8N1 frame, consumer always ready
    vcnt0 = 0; cap0.delete();
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_count", 32'(cap0.size()), 32'd1);
    if (cap0.size() > 0) check("a5_data", 32'(cap0[0]), 32'hA5);
    check("a5_valid_cycles", 32'(vcnt0), 32'd1);
    check("a5_flags", {29'd0, ferr0, perr0, ovr0}, 32'd0);
    check("a5_busy", 32'(busy0), 32'd0);

    // Even parity: 0x03 needs parity 0, send 1
    cap1.delete();
    send(1, 8'h03, 1'b1, 1'b1, 1'b1);
    check("par_count", 32'(cap1.size()), 32'd1);
    if (cap1.size() > 0) check("par_data", 32'(cap1[0]), 32'h03);
    check("par_err", 32'(perr1), 32'd1);
    check("par_ferr", 32'(ferr1), 32'd0);
    err_clr1 = 1'b1; @(negedge clk); err_clr1 = 1'b0; @(negedge clk);
    check("par_clr", 32'(perr1), 32'd0);
    send(1, 8'h07, 1'b1, 1'b1, 1'b1);
    check("par_good", 32'(perr1), 32'd0);
    check("par_good_data", 32'(cap1.size() > 1 ? cap1[1] : 8'hFF), 32'h07);

    // Framing error, then a clean frame
    cap0.delete();
    send(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    check("ferr_set", 32'(ferr0), 32'd1);
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    check("ferr_count", 32'(cap0.size()), 32'd2);
    if (cap0.size() == 2) begin
      check("ferr_data", 32'(cap0[0]), 32'h5A);
      check("after_ferr_data", 32'(cap0[1]), 32'h11);
    end
    err_clr0 = 1'b1; @(negedge clk); err_clr0 = 1'b0; @(negedge clk);
    check("ferr_clr", 32'(ferr0), 32'd0);

    // Overrun: 17 frames into a 16-deep FIFO
    rx_ready0 = 1'b0; cap0.delete();
    for (int i = 0; i < 17; i++) send(0, 8'(i), 1'b0, 1'b0, 1'b1);
    check("ovr_level", 32'(rx_level0), 32'd16);
    check("ovr_flag", 32'(ovr0), 32'd1);
    check("ovr_head", 32'(rx_data0), 32'h00);
    rx_ready0 = 1'b1;
    repeat (20) @(negedge clk);
    check("drain_count", 32'(cap0.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < cap0.size()) check("drain_data", 32'(cap0[i]), 32'(i));
    check("drain_level", 32'(rx_level0), 32'd0);
    err_clr0 = 1'b1; @(negedge clk); err_clr0 = 1'b0; @(negedge clk);
    check("ovr_clr", 32'(ovr0), 32'd0);

    // 0.4-bit glitch on idle line
    cap0.delete();
    line0 = 1'b0; repeat (4) @(negedge clk);
    line0 = 1'b1; repeat (30) @(negedge clk);
    check("glitch_push", 32'(cap0.size()), 32'd0);
    check("glitch_busy", 32'(busy0), 32'd0);
    check("glitch_flags", {29'd0, ferr0, perr0, ovr0}, 32'd0);

    // Reset in the middle of a frame
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    line0 = 1'b0; repeat (5) @(negedge clk);
    check("mid_busy", 32'(busy0), 32'd1);
    reset = 1'b1; line0 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (120) @(negedge clk);
    check("mid_level", 32'(rx_level0), 32'd0);
    check("mid_push", 32'(cap0.size()), 32'd0);
    check("mid_busy_after", 32'(busy0), 32'd0);

`ifdef UART_RX_MONITOR_EXPECT_EN
    exp0 = 8'h41;
    send(0, 8'h42, 1'b0, 1'b0, 1'b1);
    check("exp_mismatch", 32'(mis0), 32'd1);
    check("exp_cnt", 32'(mcnt0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
